fetch_stage: RTL and testbench

- Instruction-fetch stage of the Riscy SoC five-stage RV32I pipeline, directly upstream of decode.
- Holds the PC and drives the instruction-bus read handshake. Its wait state is what produces the hazard unit's fetch-wait-for-bus condition.
- Owns the fetch/decode pipeline register and applies the stall, flush and mispredict-redirect controls computed by the hazard unit.
- Optional static BTFN predictor supplies early redirects for JAL and B-type instructions.

---
 rtl/fetch_stage.sv | 164 ++++++++++++++++
 tb/tb_fetch_stage.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage: instruction-fetch stage of the Riscy RV32I pipeline.
// Holds the PC, drives the instruction-bus read handshake and owns the
// fetch/decode pipeline register (stall, flush and mispredict redirect).
// Optional static BTFN predictor enabled by defining FETCH_BTFN_PREDICT_EN.
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_stall_in,
    input  logic        decode_stall_in,
    input  logic        decode_flush_in,
    input  logic        mem_branch_mispredicted_in,
    input  logic [31:0] mem_branch_pc_in,
    output logic [31:0] instr_address_out,
    output logic        instr_read_out,
    input  logic [31:0] instr_read_value_in,
    input  logic        instr_ready_in,
    output logic [31:0] decode_pc_out,
    output logic [31:0] decode_instr_out,
    output logic        decode_valid_out,
    output logic        decode_branch_predicted_taken_out
);

    // RUN: normal fetching. REDIRECT: a mispredict arrived while the bus was
    // mid-read; wait for that read to finish before jumping to pending_pc.
    typedef enum logic {
        RUN      = 1'b0,
        REDIRECT = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        started;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] pending_pc;
    logic [31:0] pending_next;
    logic        squash;

    logic        bus_wait;
    logic        fetch_done;
    logic [31:0] redirect_pc;
    logic        pred_taken;
    logic [31:0] next_pc;

    assign instr_read_out    = started;
    assign instr_address_out = pc & 32'hFFFF_FFFC;
    assign bus_wait          = started & ~instr_ready_in;
    assign fetch_done        = started & instr_ready_in;
    assign redirect_pc       = mem_branch_pc_in & 32'hFFFF_FFFC;

`ifdef FETCH_BTFN_PREDICT_EN
    logic [6:0]  opcode;
    logic [31:0] b_imm;
    logic [31:0] j_imm;
    logic        is_jal;
    logic        is_branch;

    // Static backward-taken/forward-not-taken prediction on the word being accepted.
    always_comb begin
        opcode    = instr_read_value_in[6:0];
        b_imm     = {{20{instr_read_value_in[31]}}, instr_read_value_in[7],
                     instr_read_value_in[30:25], instr_read_value_in[11:8], 1'b0};
        j_imm     = {{12{instr_read_value_in[31]}}, instr_read_value_in[19:12],
                     instr_read_value_in[20], instr_read_value_in[30:21], 1'b0};
        is_jal    = (opcode == 7'b1101111);
        is_branch = (opcode == 7'b1100011);
        pred_taken = fetch_done & (is_jal | (is_branch & instr_read_value_in[31]));
        next_pc    = pc + 32'd4;
        if (pred_taken) begin
            next_pc = pc + (is_jal ? j_imm : b_imm);
        end
    end
`else
    assign pred_taken = 1'b0;
    assign next_pc    = pc + 32'd4;
`endif

    // Next-state logic for the PC / redirect FSM.
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        state_next   = state;
        pc_next      = pc;
        pending_next = pending_pc;
        squash       = 1'b0;
        case (state)
            RUN: begin
                if (mem_branch_mispredicted_in && bus_wait) begin
                    // The address must not move mid-transaction: park the target.
                    pending_next = redirect_pc;
                    state_next   = REDIRECT;
                end else if (mem_branch_mispredicted_in) begin
                    pc_next = redirect_pc;
                end else if (!fetch_stall_in && fetch_done) begin
                    pc_next = next_pc;
                end
            end
            REDIRECT: begin
                if (mem_branch_mispredicted_in) begin
                    pending_next = redirect_pc;
                end
                if (instr_ready_in) begin
                    // The outstanding read completes; its word is wrong-path.
                    pc_next    = mem_branch_mispredicted_in ? redirect_pc : pending_pc;
                    state_next = RUN;
                    squash     = 1'b1;
                end
            end
            default: state_next = RUN;
        endcase
    end

    // PC, redirect state and bus-request registers.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            state      <= RUN;
            pc         <= RESET_PC;
            pending_pc <= 32'h0000_0000;
            started    <= 1'b0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            pending_pc <= pending_next;
            started    <= 1'b1;
        end
    end

    // Fetch/decode pipeline register: squash, then stall, then flush, then load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            decode_pc_out                     <= 32'h0000_0000;
            decode_instr_out                  <= NOP_INSTR;
            decode_valid_out                  <= 1'b0;
            decode_branch_predicted_taken_out <= 1'b0;
        end else if (squash) begin
            decode_pc_out                     <= 32'h0000_0000;
            decode_instr_out                  <= NOP_INSTR;
            decode_valid_out                  <= 1'b0;
            decode_branch_predicted_taken_out <= 1'b0;
        end else if (decode_stall_in) begin
            decode_pc_out                     <= decode_pc_out;
            decode_instr_out                  <= decode_instr_out;
            decode_valid_out                  <= decode_valid_out;
            decode_branch_predicted_taken_out <= decode_branch_predicted_taken_out;
        end else if (decode_flush_in || !fetch_done) begin
            // No word arrived this cycle, or hazard logic asked for a bubble.
            decode_pc_out                     <= 32'h0000_0000;
            decode_instr_out                  <= NOP_INSTR;
            decode_valid_out                  <= 1'b0;
            decode_branch_predicted_taken_out <= 1'b0;
        end else begin
            decode_pc_out                     <= pc;
            decode_instr_out                  <= instr_read_value_in;
            decode_valid_out                  <= 1'b1;
            decode_branch_predicted_taken_out <= pred_taken;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage: self-checking bench for fetch_stage. Instructions expected
// to reach decode are queued when stimulus is driven and compared when the
// DUT presents a valid decode entry. Define FETCH_BTFN_PREDICT_EN to cover
// the predictor.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pred;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_stall_in = 1'b0;
    logic        decode_stall_in = 1'b0;
    logic        decode_flush_in = 1'b0;
    logic        mem_branch_mispredicted_in = 1'b0;
    logic [31:0] mem_branch_pc_in = 32'h0;
    logic [31:0] instr_address_out;
    logic        instr_read_out;
    logic [31:0] instr_read_value_in;
    logic        instr_ready_in = 1'b1;
    logic [31:0] decode_pc_out;
    logic [31:0] decode_instr_out;
    logic        decode_valid_out;
    logic        decode_branch_predicted_taken_out;

    // Memory model: address-tagged addi words, with one overridable location.
    logic        ovr_en = 1'b0;
    logic [31:0] ovr_addr = 32'h0;
    logic [31:0] ovr_word = 32'h0;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic mon_stall;

    fetch_stage dut (
        .clk                               (clk),
        .reset                             (reset),
        .fetch_stall_in                    (fetch_stall_in),
        .decode_stall_in                   (decode_stall_in),
        .decode_flush_in                   (decode_flush_in),
        .mem_branch_mispredicted_in        (mem_branch_mispredicted_in),
        .mem_branch_pc_in                  (mem_branch_pc_in),
        .instr_address_out                 (instr_address_out),
        .instr_read_out                    (instr_read_out),
        .instr_read_value_in               (instr_read_value_in),
        .instr_ready_in                    (instr_ready_in),
        .decode_pc_out                     (decode_pc_out),
        .decode_instr_out                  (decode_instr_out),
        .decode_valid_out                  (decode_valid_out),
        .decode_branch_predicted_taken_out (decode_branch_predicted_taken_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] tag_word(input logic [31:0] addr);
        return {addr[24:0], 7'h13};
    endfunction

    assign instr_read_value_in = (ovr_en && instr_address_out == ovr_addr) ? ovr_word
                                                                           : tag_word(instr_address_out);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] instr, input logic pred);
        exp_t e;
        e.pc    = pc;
        e.instr = instr;
        e.pred  = pred;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of hazard/bus inputs at the falling edge, then advance.
    task automatic cyc(input logic fs, input logic ds, input logic df,
                       input logic mp, input logic [31:0] mpc, input logic rdy);
        fetch_stall_in             = fs;
        decode_stall_in            = ds;
        decode_flush_in            = df;
        mem_branch_mispredicted_in = mp;
        mem_branch_pc_in           = mpc;
        instr_ready_in             = rdy;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_bubble(input string tag);
        check({tag, "_valid"}, {31'b0, decode_valid_out}, 32'd0);
        check({tag, "_instr"}, decode_instr_out, NOP);
        check({tag, "_pc"}, decode_pc_out, 32'd0);
    endtask

    // Scoreboard: every newly delivered valid decode entry must match the queue head.
    always @(posedge clk) begin
        mon_stall = decode_stall_in;
        #2;
        if (!reset && !mon_stall && decode_valid_out) begin
            check("sb_nonempty", {31'b0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_pc", decode_pc_out, e.pc);
                check("sb_instr", decode_instr_out, e.instr);
                check("sb_pred", {31'b0, decode_branch_predicted_taken_out}, {31'b0, e.pred});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state.
        @(negedge clk);
        @(negedge clk);
        check("rst_read", {31'b0, instr_read_out}, 32'd0);
        check("rst_addr", instr_address_out, 32'h0);
        check_bubble("rst");
        check("rst_pred", {31'b0, decode_branch_predicted_taken_out}, 32'd0);

        // Release reset; request rises one cycle later.
        reset = 1'b0;
        check("req_low_after_rst", {31'b0, instr_read_out}, 32'd0);
        cyc(0, 0, 0, 0, 0, 1);
        check("req_rise", {31'b0, instr_read_out}, 32'd1);
        check("first_addr", instr_address_out, 32'h0);
        check_bubble("pre_fetch");

        // Sequential fetch 0x0, 0x4.
        push(32'h0, tag_word(32'h0), 1'b0);
        cyc(0, 0, 0, 0, 0, 1);
        check("seq_addr4", instr_address_out, 32'h4);
        push(32'h4, tag_word(32'h4), 1'b0);
        cyc(0, 0, 0, 0, 0, 1);
        check("wait_addr0", instr_address_out, 32'h8);

        // Bus wait for three cycles at 0x8; hazard stalls fetch and flushes decode.
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 1, 0, 0, 0);
            check("wait_addr", instr_address_out, 32'h8);
            check_bubble("wait");
        end
        push(32'h8, tag_word(32'h8), 1'b0);
        cyc(0, 0, 0, 0, 0, 1);
        check("after_wait_addr", instr_address_out, 32'hC);

        // Mispredict with bus ready: immediate redirect.
        cyc(0, 0, 1, 1, 32'h100, 1);
        check("mp_ready_addr", instr_address_out, 32'h100);
        check_bubble("mp_ready");
        push(32'h100, tag_word(32'h100), 1'b0);
        cyc(0, 0, 0, 0, 0, 1);
        check("mp_ready_dpc", decode_pc_out, 32'h100);

        // Reach 0x10, then mispredict to 0x203 while the bus waits.
        cyc(0, 0, 1, 1, 32'h10, 1);
        check("mp_wait_start", instr_address_out, 32'h10);
        cyc(1, 0, 1, 1, 32'h203, 0);
        check("mp_wait_hold1", instr_address_out, 32'h10);
        cyc(1, 0, 1, 0, 0, 0);
        check("mp_wait_hold2", instr_address_out, 32'h10);
        cyc(0, 0, 0, 0, 0, 1);
        check("redirect_addr", instr_address_out, 32'h200);
        check_bubble("squash");
        push(32'h200, tag_word(32'h200), 1'b0);
        cyc(0, 0, 0, 0, 0, 1);
        check("redirect_next", instr_address_out, 32'h204);

        // Decode stall beats flush; then flush alone loads a bubble.
        for (int i = 0; i < 2; i++) begin
            cyc(1, 1, 1, 0, 0, 1);
            check("stall_pc", decode_pc_out, 32'h200);
            check("stall_instr", decode_instr_out, tag_word(32'h200));
            check("stall_valid", {31'b0, decode_valid_out}, 32'd1);
            check("stall_addr", instr_address_out, 32'h204);
        end
        cyc(1, 0, 1, 0, 0, 1);
        check_bubble("flush_after_stall");
        push(32'h204, tag_word(32'h204), 1'b0);
        cyc(0, 0, 0, 0, 0, 1);
        check("resume_addr", instr_address_out, 32'h208);

        // PC wraps modulo 2^32.
        cyc(0, 0, 1, 1, 32'hFFFF_FFFC, 1);
        check("wrap_top", instr_address_out, 32'hFFFF_FFFC);
        push(32'hFFFF_FFFC, tag_word(32'hFFFF_FFFC), 1'b0);
        cyc(0, 0, 0, 0, 0, 1);
        check("wrap_zero", instr_address_out, 32'h0);

        // Control-flow words at 0x40.
        ovr_en   = 1'b1;
        ovr_addr = 32'h40;
`ifdef FETCH_BTFN_PREDICT_EN
        ovr_word = 32'hFE00_0CE3;                 // beq x0,x0,-8
        cyc(0, 0, 1, 1, 32'h40, 1);
        push(32'h40, 32'hFE00_0CE3, 1'b1);
        cyc(0, 0, 0, 0, 0, 1);
        check("btfn_back", instr_address_out, 32'h38);
        ovr_word = 32'h0000_0463;                 // beq x0,x0,+8
        cyc(0, 0, 1, 1, 32'h40, 1);
        push(32'h40, 32'h0000_0463, 1'b0);
        cyc(0, 0, 0, 0, 0, 1);
        check("btfn_fwd", instr_address_out, 32'h44);
        ovr_word = 32'h1000_006F;                 // jal x0,+0x100
        cyc(0, 0, 1, 1, 32'h40, 1);
        push(32'h40, 32'h1000_006F, 1'b1);
        cyc(0, 0, 0, 0, 0, 1);
        check("btfn_jal", instr_address_out, 32'h140);
`else
        ovr_word = 32'h1000_006F;                 // jal x0,+0x100: no prediction
        cyc(0, 0, 1, 1, 32'h40, 1);
        push(32'h40, 32'h1000_006F, 1'b0);
        cyc(0, 0, 0, 0, 0, 1);
        check("nopred_jal", instr_address_out, 32'h44);
`endif
        ovr_en = 1'b0;
        cyc(0, 0, 1, 0, 0, 1);

        // Reset in the middle of a bus wait.
        check("sb_empty", exp_q.size(), 32'd0);
        cyc(1, 0, 1, 0, 0, 0);
        #3 reset = 1'b1;
        #1;
        check("midrst_read", {31'b0, instr_read_out}, 32'd0);
        check("midrst_addr", instr_address_out, 32'h0);
        check_bubble("midrst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
